// File: rtl/axis_i2c_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axis_i2c_rx
//   I2C target receiver. Watches an externally driven bus, decodes START/STOP,
//   matches its own 7-bit write address, ACKs accepted bytes by pulling SDA low
//   and packs the bytes big-endian into DATA_WIDTH words on an AXI-Stream
//   master port.
//
//   Optional build macro: I2C_RX_PARTIAL_FLUSH_EN
//     defined   - a partial word pending at STOP / repeated START is emitted,
//                 zero-padded in the LSBs (or dropped with overflow if full).
//     undefined - partial words are discarded silently.
//
// Ports
//   clk            system clock, at least 8x SCL
//   arstn          asynchronous active-low reset
//   scl_i, sda_i   raw bus pad inputs (asynchronous)
//   sda_oe         1 = drive SDA low, 0 = release
//   m_axis_tvalid  word valid
//   m_axis_tready  downstream ready
//   m_axis_tdata   received word, first bus byte in the MSBs
//   overflow       sticky: a word was NACKed/dropped because output was full
// -----------------------------------------------------------------------------
module axis_i2c_rx #(
  parameter logic [6:0] I2C_ADDR   = 7'h50,
  parameter int         DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  overflow
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(BYTES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  state_t                state, state_nxt;
  logic                  scl_p0, scl_p1, scl_p2;
  logic                  sda_p0, sda_p1, sda_p2;
  logic                  scl_rise, scl_fall, start_cond, stop_cond, bus_evt;
  logic [2:0]            bit_cnt;
  logic                  byte_rdy;
  logic [BCW-1:0]        byte_cnt;
  logic [7:0]            shift;
  logic [DATA_WIDTH-1:0] asm_word, word_fill, load_data;
  logic                  oe_nxt, shift_en, decide, full, last;
  logic                  store_byte, word_end, load, set_ovf;

  // stage p0/p1: synchroniser, p2: history for edge detection
  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign start_cond = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_cond  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign bus_evt    = start_cond | stop_cond;

  // byte_rdy marks "8 bits in, waiting for the falling edge that ends bit 8"
  assign shift_en = scl_rise & ~byte_rdy & ((state == ADDR) || (state == DATA));
  assign decide   = scl_fall & byte_rdy;
  assign full     = m_axis_tvalid & ~m_axis_tready;
  assign last     = (byte_cnt == LAST);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    word_fill = asm_word;
    for (int i = 0; i < BYTES; i++)
      if (byte_cnt == BCW'(i)) word_fill[8*(BYTES-1-i) +: 8] = shift;
  end

  always_comb begin
    state_nxt  = state;
    oe_nxt     = sda_oe;
    store_byte = 1'b0;
    word_end   = 1'b0;
    load       = 1'b0;
    load_data  = word_fill;
    set_ovf    = 1'b0;
    if (bus_evt) begin
      state_nxt = stop_cond ? IDLE : ADDR;
      oe_nxt    = 1'b0;
`ifdef I2C_RX_PARTIAL_FLUSH_EN
      if (byte_cnt != '0) begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          load      = 1'b1;
          load_data = asm_word;
        end
      end
`endif
    end else begin
      case (state)
        IDLE: oe_nxt = 1'b0;
        ADDR: begin
          if (decide) begin
            if ((shift[7:1] == I2C_ADDR) && !shift[0]) begin
              state_nxt = ADDR_ACK;
              oe_nxt    = 1'b1;
            end else begin
              state_nxt = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            state_nxt = DATA;
            oe_nxt    = 1'b0;
          end
        end
        DATA: begin
          if (decide) begin
            state_nxt = DATA_ACK;
            if (last) begin
              word_end = 1'b1;
              // a handshake in this cycle frees the register, so tready=1 is not full
              if (full) begin
                set_ovf = 1'b1;
              end else begin
                oe_nxt = 1'b1;
                load   = 1'b1;
              end
            end else begin
              oe_nxt     = 1'b1;
              store_byte = 1'b1;
            end
          end
        end
        IGNORE:  oe_nxt = 1'b0;
        default: begin
          state_nxt = IDLE;
          oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_p0        <= 1'b1;
      scl_p1        <= 1'b1;
      scl_p2        <= 1'b1;
      sda_p0        <= 1'b1;
      sda_p1        <= 1'b1;
      sda_p2        <= 1'b1;
      sda_oe        <= 1'b0;
      bit_cnt       <= '0;
      byte_rdy      <= 1'b0;
      byte_cnt      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      overflow      <= 1'b0;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
      sda_oe <= oe_nxt;
      if (bus_evt) begin
        bit_cnt  <= '0;
        byte_rdy <= 1'b0;
        byte_cnt <= '0;
      end else begin
        if (shift_en) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_rdy <= 1'b1;
        end
        if (decide) byte_rdy <= 1'b0;
        if (store_byte)    byte_cnt <= byte_cnt + 1'b1;
        else if (word_end) byte_cnt <= '0;
      end
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= load_data;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (set_ovf) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift <= {shift[6:0], sda_p1};
    if (bus_evt || word_end) asm_word <= '0;
    else if (store_byte)     asm_word <= word_fill;
  end

endmodule

// File: tb/tb_axis_i2c_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axis_i2c_rx
//   Bench for axis_i2c_rx: a bit-level I2C master model drives an open-drain
//   bus (SDA = master AND NOT sda_oe), AXIS beats and sda_oe pulse widths are
//   recorded by a monitor, and directed vectors are compared with hand-computed
//   expectations.
// -----------------------------------------------------------------------------
module tb_axis_i2c_rx;
  localparam int DW = 16;
  localparam int Q  = 4;   // clk cycles per quarter SCL period
  localparam int H  = 8;   // clk cycles SCL high

  typedef struct {
    string       name;
    logic [7:0]  addr;
    int          n;
    logic [31:0] d;
    logic [4:0]  ack;
    int          nb;
    logic [31:0] bx;
  } vec_t;

  logic clk = 1'b0, arstn = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic tready_m = 1'b1, tog = 1'b0, tog_en = 1'b0;
  logic sda_oe, tvalid, tready, overflow, sda_bus;
  logic [DW-1:0] tdata;

  assign sda_bus = sda_m & ~sda_oe;
  assign tready  = tog_en ? tog : tready_m;

  always #5 clk = ~clk;

  axis_i2c_rx #(.I2C_ADDR(7'h50), .DATA_WIDTH(DW)) dut (
    .clk(clk), .arstn(arstn), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .overflow(overflow)
  );

  int checks = 0, failures = 0;
  logic [DW-1:0] beats [$];
  int pulses [$];
  int run = 0, stall_seen = 0, stall_bad = 0;
  logic stalled = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) tog <= ~tog;

  always @(negedge clk) begin
    #2;
    if (tvalid && tready) beats.push_back(tdata);
    if (stalled && tvalid) begin
      stall_seen++;
      if (tdata !== stall_data) stall_bad++;
    end
    stalled    = tvalid & ~tready;
    stall_data = tdata;
    if (sda_oe) run++;
    else if (run != 0) begin
      pulses.push_back(run);
      run = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    arstn = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tog_en = 1'b0; tready_m = 1'b1;
    wait_n(4);
    arstn = 1'b1;
    wait_n(4);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_n(Q);
    scl_m = 1'b1; wait_n(Q);
    sda_m = 1'b0; wait_n(Q);
    scl_m = 1'b0; wait_n(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_n(Q);
    scl_m = 1'b1; wait_n(Q);
    sda_m = 1'b1; wait_n(Q);
  endtask

  // abort_bit >= 0: assert reset while SCL is high during that bit and return
  task automatic i2c_byte(input logic [7:0] b, input int abort_bit, output logic ack);
    ack = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_n(Q);
      scl_m = 1'b1;
      if (7 - i == abort_bit) begin
        wait_n(Q);
        #1 arstn = 1'b0;
        return;
      end
      wait_n(H);
      scl_m = 1'b0; wait_n(Q);
    end
    sda_m = 1'b1; wait_n(Q);
    scl_m = 1'b1; wait_n(H/2);
    ack = ~sda_bus; wait_n(H/2);
    scl_m = 1'b0; wait_n(Q);
  endtask

  task automatic send(input logic [7:0] addr, input int n, input logic [31:0] d,
                      output logic [4:0] acks);
    logic a;
    acks = '0;
    i2c_byte(addr, -1, a);
    acks[0] = a;
    for (int k = 0; k < n; k++) begin
      i2c_byte(d[31-8*k -: 8], -1, a);
      acks[k+1] = a;
    end
  endtask

  task automatic chk_pulses(input string name, input int base, input int n_exp);
    chk({name, "_npulse"}, pulses.size() - base, n_exp);
    for (int i = base; i < pulses.size(); i++) chk({name, "_pwidth"}, pulses[i], 16);
  endtask

  vec_t vecs [6];
  logic [4:0] acks;
  logic a, ack_all;
  int bb, pb, rs_n;
  logic [47:0] rs_exp;
  logic [7:0] tog_bytes [6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"wr_1234", 8'hA0, 2, 32'h12340000, 5'b00111, 1, 32'h12340000};
    vecs[1] = '{"addr_51", 8'hA2, 2, 32'h12340000, 5'b00000, 0, 32'h00000000};
    vecs[2] = '{"read_50", 8'hA1, 2, 32'h12340000, 5'b00000, 0, 32'h00000000};
    vecs[3] = '{"wr_4",    8'hA0, 4, 32'hAABBCCDD, 5'b11111, 2, 32'hAABBCCDD};
`ifdef I2C_RX_PARTIAL_FLUSH_EN
    vecs[4] = '{"wr_3",    8'hA0, 3, 32'h01020300, 5'b01111, 2, 32'h01020300};
    vecs[5] = '{"wr_1",    8'hA0, 1, 32'h5A000000, 5'b00011, 1, 32'h5A000000};
    rs_n    = 3;
    rs_exp  = {16'h0102, 16'h0300, 16'h0405};
`else
    vecs[4] = '{"wr_3",    8'hA0, 3, 32'h01020300, 5'b01111, 1, 32'h01020000};
    vecs[5] = '{"wr_1",    8'hA0, 1, 32'h5A000000, 5'b00011, 0, 32'h00000000};
    rs_n    = 2;
    rs_exp  = {16'h0102, 16'h0405, 16'h0000};
`endif
    tog_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    do_reset;
    chk("rst_sda_oe",   32'(sda_oe),   0);
    chk("rst_tvalid",   32'(tvalid),   0);
    chk("rst_tdata",    32'(tdata),    0);
    chk("rst_overflow", 32'(overflow), 0);

    for (int v = 0; v < 6; v++) begin
      do_reset;
      bb = beats.size();
      pb = pulses.size();
      i2c_start;
      send(vecs[v].addr, vecs[v].n, vecs[v].d, acks);
      i2c_stop;
      wait_n(40);
      chk({vecs[v].name, "_acks"},   32'(acks), 32'(vecs[v].ack));
      chk({vecs[v].name, "_nbeats"}, beats.size() - bb, vecs[v].nb);
      for (int i = 0; i < vecs[v].nb; i++)
        if (bb + i < beats.size())
          chk({vecs[v].name, "_beat"}, 32'(beats[bb+i]), 32'(vecs[v].bx[31-16*i -: 16]));
      chk({vecs[v].name, "_ovf"},    32'(overflow), 0);
      chk({vecs[v].name, "_tvalid"}, 32'(tvalid),   0);
      chk_pulses(vecs[v].name, pb, $countones(vecs[v].ack));
    end

    // output held full: second word's last byte is NACKed
    do_reset;
    tready_m = 1'b0;
    bb = beats.size();
    pb = pulses.size();
    i2c_start;
    send(8'hA0, 4, 32'hAABBCCDD, acks);
    chk("ovf_acks",   32'(acks),     32'(5'b01111));
    chk("ovf_flag",   32'(overflow), 1);
    chk("ovf_tvalid", 32'(tvalid),   1);
    chk("ovf_tdata",  32'(tdata),    32'h0000AABB);
    i2c_stop;
    wait_n(10);
    chk("ovf_tdata_held", 32'(tdata), 32'h0000AABB);
    tready_m = 1'b1;
    wait_n(10);
    chk("ovf_nbeats", beats.size() - bb, 1);
    if (beats.size() > bb) chk("ovf_beat", 32'(beats[bb]), 32'h0000AABB);
    chk("ovf_tvalid_after", 32'(tvalid),   0);
    chk("ovf_sticky",       32'(overflow), 1);
    chk_pulses("ovf", pb, 4);

    // repeated START in the middle of a word
    do_reset;
    bb = beats.size();
    i2c_start;
    send(8'hA0, 3, 32'h01020300, acks);
    chk("rs_acks1", 32'(acks), 32'(5'b01111));
    i2c_start;
    send(8'hA0, 2, 32'h04050000, acks);
    chk("rs_acks2", 32'(acks), 32'(5'b00111));
    i2c_stop;
    wait_n(40);
    chk("rs_nbeats", beats.size() - bb, rs_n);
    for (int i = 0; i < rs_n; i++)
      if (bb + i < beats.size())
        chk("rs_beat", 32'(beats[bb+i]), 32'(rs_exp[47-16*i -: 16]));

    // reset during the second data bit of a byte, with tvalid and overflow set
    do_reset;
    tready_m = 1'b0;
    i2c_start;
    send(8'hA0, 4, 32'hAABBCCDD, acks);
    chk("mid_pre_ovf", 32'(overflow), 1);
    i2c_byte(8'hEE, 1, a);
    #2;
    chk("mid_rst_sda_oe",   32'(sda_oe),   0);
    chk("mid_rst_tvalid",   32'(tvalid),   0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    scl_m = 1'b1; sda_m = 1'b1; tready_m = 1'b1;
    wait_n(4);
    arstn = 1'b1;
    wait_n(4);
    bb = beats.size();
    i2c_start;
    send(8'hA0, 2, 32'h12340000, acks);
    i2c_stop;
    wait_n(40);
    chk("mid_acks",   32'(acks), 32'(5'b00111));
    chk("mid_nbeats", beats.size() - bb, 1);
    if (beats.size() > bb) chk("mid_beat", 32'(beats[bb]), 32'h00001234);
    chk("mid_ovf", 32'(overflow), 0);

    // back-to-back words with tready toggling every cycle
    do_reset;
    tog_en = 1'b1;
    bb = beats.size();
    i2c_start;
    i2c_byte(8'hA0, -1, a);
    ack_all = a;
    for (int k = 0; k < 6; k++) begin
      i2c_byte(tog_bytes[k], -1, a);
      ack_all = ack_all & a;
    end
    i2c_stop;
    wait_n(40);
    chk("tog_acks",   32'(ack_all), 1);
    chk("tog_nbeats", beats.size() - bb, 3);
    for (int i = 0; i < 3; i++)
      if (bb + i < beats.size())
        chk("tog_beat", 32'(beats[bb+i]), 32'({tog_bytes[2*i], tog_bytes[2*i+1]}));
    chk("tog_ovf", 32'(overflow), 0);
    chk("stall_seen",   32'(stall_seen != 0), 1);
    chk("stall_stable", stall_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
